// File: rtl/vs_pkg.sv
// Shared fixed-point constants and the operand vector type for the vertex-shader datapath.
// Operands are 4Q20 signed; inverse-length results are unsigned 1Q24.
package vs_pkg;

    localparam int Q4_20_W      = 24;
    localparam int Q1_24_W      = 25;
    localparam int INV_SQRT_LAT = 12;

    localparam logic [Q4_20_W-1:0] ONE_Q4_20 = 24'h100000;

    typedef struct packed {
        logic [Q4_20_W-1:0] x;
        logic [Q4_20_W-1:0] y;
        logic [Q4_20_W-1:0] z;
    } vec3_t;

endpackage

// File: rtl/inv_sqrt.sv
// Fixed-latency 1/|v| unit: 4Q20 x/y/z in, 1Q24 out LAT clock edges later.
// Results that do not fit in 1Q24 (including the zero vector) saturate to all ones.
module inv_sqrt
    import vs_pkg::*;
#(
    parameter int LAT = INV_SQRT_LAT
) (
    input  logic               clk,
    input  logic [Q4_20_W-1:0] x_i,
    input  logic [Q4_20_W-1:0] y_i,
    input  logic [Q4_20_W-1:0] z_i,
    output logic [Q1_24_W-1:0] inv_o
);

    localparam logic [63:0] SAT = 64'h1FF_FFFF;

    logic signed [47:0] sqX, sqY, sqZ;
    logic [49:0]        sumSq, cand, candSq;
    logic [24:0]        root;
    logic [63:0]        quot;
    logic [Q1_24_W-1:0] result;
    logic [Q1_24_W-1:0] stage_q [LAT];

    // |v|^2 is Q8.40, so its integer square root is |v| in Q20 and 2^44/root is 1/|v| in Q24.
    always_comb begin
        sqX    = $signed(x_i) * $signed(x_i);
        sqY    = $signed(y_i) * $signed(y_i);
        sqZ    = $signed(z_i) * $signed(z_i);
        sumSq  = {2'b00, sqX} + {2'b00, sqY} + {2'b00, sqZ};
        root   = '0;
        cand   = '0;
        candSq = '0;
        for (int b = 24; b >= 0; b--) begin
            cand   = {25'd0, root | (25'd1 << b)};
            candSq = cand * cand;
            if (candSq <= sumSq) begin
                root = cand[24:0];
            end
        end
        quot   = '0;
        result = '1;
        if (root != '0) begin
            quot = (64'd1 << 44) / {39'd0, root};
            if (quot <= SAT) begin
                result = quot[Q1_24_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        stage_q[0] <= result;
        for (int k = 1; k < LAT; k++) begin
            stage_q[k] <= stage_q[k-1];
        end
    end

    assign inv_o = stage_q[LAT-1];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant over N requesters: search starts at the pointer, first valid wins,
// and the pointer moves just past the winner. No grant is issued while reset is held.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 srst_n,
    input  logic [N-1:0]         valid_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] grantIdx_o,
    output logic                 accept_o
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] rrPtr_q, rrPtr_d;
    int               idx;

    always_comb begin
        grant_o    = '0;
        grantIdx_o = '0;
        accept_o   = 1'b0;
        idx        = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(rrPtr_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!accept_o && srst_n && valid_i[idx]) begin
                grant_o[idx] = 1'b1;
                grantIdx_o   = IDX_W'(idx);
                accept_o     = 1'b1;
            end
        end
    end

    always_comb begin
        rrPtr_d = rrPtr_q;
        if (accept_o) begin
            rrPtr_d = (int'(grantIdx_o) == N - 1) ? '0 : grantIdx_o + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            rrPtr_q <= '0;
        end else begin
            rrPtr_q <= rrPtr_d;
        end
    end

endmodule

// File: rtl/inv_sqrt_arbiter.sv
// Shares one pipelined inv_sqrt unit among NUM_REQ requesters; a tag pipe running in
// lockstep with the unit routes each fixed-latency result back to the requester that issued it.
module inv_sqrt_arbiter
    import vs_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LAT     = INV_SQRT_LAT
) (
    input  logic                       clk,
    input  logic                       srst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*Q4_20_W-1:0] req_x,
    input  logic [NUM_REQ*Q4_20_W-1:0] req_y,
    input  logic [NUM_REQ*Q4_20_W-1:0] req_z,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [Q1_24_W-1:0]         rsp_data,
    output logic                       idle
);

    localparam int TAG_W = $clog2(NUM_REQ);

    logic               accept;
    logic [TAG_W-1:0]   grantIdx;
    vec3_t              op_q, op_d;
    logic [LAT:0]       tagValid_q;
    logic [TAG_W-1:0]   tag_q [LAT+1];
    logic [NUM_REQ-1:0] rspValid_q, rspValid_d;
    logic [Q1_24_W-1:0] rspData_q, rspData_d;
    logic [Q1_24_W-1:0] invOut;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk        (clk),
        .srst_n     (srst_n),
        .valid_i    (req_valid),
        .grant_o    (req_ready),
        .grantIdx_o (grantIdx),
        .accept_o   (accept)
    );

    inv_sqrt #(
        .LAT (LAT)
    ) u_inv_sqrt (
        .clk   (clk),
        .x_i   (op_q.x),
        .y_i   (op_q.y),
        .z_i   (op_q.z),
        .inv_o (invOut)
    );

    always_comb begin
        op_d = op_q;
        if (accept) begin
            op_d.x = req_x[int'(grantIdx)*Q4_20_W +: Q4_20_W];
            op_d.y = req_y[int'(grantIdx)*Q4_20_W +: Q4_20_W];
            op_d.z = req_z[int'(grantIdx)*Q4_20_W +: Q4_20_W];
        end
    end

    // Stage LAT of the tag pipe lines up with the inv_sqrt output for the same request.
    always_comb begin
        rspValid_d = '0;
        rspData_d  = rspData_q;
        if (tagValid_q[LAT]) begin
            rspValid_d[tag_q[LAT]] = 1'b1;
            rspData_d              = invOut;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            op_q       <= '0;
            tagValid_q <= '0;
            rspValid_q <= '0;
            rspData_q  <= '0;
        end else begin
            op_q       <= op_d;
            tagValid_q <= {tagValid_q[LAT-1:0], accept};
            rspValid_q <= rspValid_d;
            rspData_q  <= rspData_d;
        end
    end

    // Tag payload needs no reset: only the valid bits decide whether it is ever used.
    always_ff @(posedge clk) begin
        tag_q[0] <= grantIdx;
        for (int k = 1; k <= LAT; k++) begin
            tag_q[k] <= tag_q[k-1];
        end
    end

    assign rsp_valid = rspValid_q;
    assign rsp_data  = rspData_q;
    assign idle      = ~(|tagValid_q) & ~accept;

endmodule

// File: tb/tb_inv_sqrt_arbiter.sv
// Self-checking bench for inv_sqrt_arbiter: randomized requesters against a cycle-level
// reference built from round-robin rules, a due-cycle response table and arithmetic 1/|v|.
module tb_inv_sqrt_arbiter;
    import vs_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int LAT     = INV_SQRT_LAT;
    localparam int RSP_LAT = LAT + 2;

    logic                       clk = 1'b0;
    logic                       srst_n;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*Q4_20_W-1:0] req_x, req_y, req_z;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [Q1_24_W-1:0]         rsp_data;
    logic                       idle;

    always #5 clk = ~clk;

    inv_sqrt_arbiter #(
        .NUM_REQ (NUM_REQ),
        .LAT     (LAT)
    ) dut (
        .clk       (clk),
        .srst_n    (srst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_z     (req_z),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .idle      (idle)
    );

    int          tests = 0;
    int          fails = 0;
    longint      cyc   = 0;
    int          rrPtr = 0;
    int          dueReq  [longint];
    logic [24:0] dueData [longint];
    logic [24:0] lastData = '0;
    logic [23:0] opX [NUM_REQ];
    logic [23:0] opY [NUM_REQ];
    logic [23:0] opZ [NUM_REQ];

    logic [NUM_REQ-1:0] obsReady, expReady, obsRspV, expRspV;
    logic [24:0]        obsData, expData;
    logic               obsIdle, expIdle;

    // Arithmetic reference: integer sqrt by bisection, then 2^44 / |v|_Q20, saturating.
    function automatic logic [24:0] refInvSqrt(input logic [23:0] x, input logic [23:0] y, input logic [23:0] z);
        longint sx, sy, sz, s, lo, hi, mid, q;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sz = longint'($signed(z));
        s  = sx * sx + sy * sy + sz * sz;
        lo = 0;
        hi = longint'(1) << 25;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= s) lo = mid;
            else hi = mid;
        end
        if (lo == 0) return 25'h1FFFFFF;
        q = (longint'(1) << 44) / lo;
        if (q > 33554431) return 25'h1FFFFFF;
        return q[24:0];
    endfunction

    task automatic newOps(input int r);
        if ($urandom_range(0, 15) == 0) begin
            opX[r] = '0; opY[r] = '0; opZ[r] = '0;
        end else begin
            opX[r] = 24'($urandom); opY[r] = 24'($urandom); opZ[r] = 24'($urandom);
        end
    endtask

    // Drives one cycle, samples the DUT mid-cycle and advances the reference model.
    task automatic stepCycle(input logic rstN, input logic [NUM_REQ-1:0] vld);
        int g;
        @(negedge clk);
        srst_n    = rstN;
        req_valid = vld;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_x[i*24 +: 24] = opX[i];
            req_y[i*24 +: 24] = opY[i];
            req_z[i*24 +: 24] = opZ[i];
        end
        #1;
        obsReady = req_ready;
        obsRspV  = rsp_valid;
        obsData  = rsp_data;
        obsIdle  = idle;
        expRspV  = '0;
        if (dueReq.exists(cyc)) begin
            expRspV[dueReq[cyc]] = 1'b1;
            lastData = dueData[cyc];
            dueReq.delete(cyc);
            dueData.delete(cyc);
        end
        expData = lastData;
        g = -1;
        if (rstN) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (g < 0 && vld[(rrPtr + i) % NUM_REQ]) g = (rrPtr + i) % NUM_REQ;
            end
        end
        expReady = '0;
        if (g >= 0) expReady[g] = 1'b1;
        expIdle = (g < 0) && (dueReq.size() == 0);
        if (!rstN) begin
            dueReq.delete();
            dueData.delete();
            rrPtr    = 0;
            lastData = '0;
        end else if (g >= 0) begin
            dueReq[cyc + RSP_LAT]  = g;
            dueData[cyc + RSP_LAT] = refInvSqrt(opX[g], opY[g], opZ[g]);
            rrPtr = (g + 1) % NUM_REQ;
        end
        cyc++;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            stepCycle(1'b0, '1);
            tests++;
            if ({obsReady, obsRspV, obsData, obsIdle} !== {expReady, expRspV, expData, expIdle}) begin
                fails++;
                $display("[TB] FAIL reset cyc=%0d ready=%b want %b rspValid=%b want %b data=%h want %h idle=%b want %b",
                         cyc - 1, obsReady, expReady, obsRspV, expRspV, obsData, expData, obsIdle, expIdle);
            end
        end
    endtask

    task automatic test_single(input string name, input int r, input logic [23:0] x, input logic [24:0] want);
        longint accCyc, hitCyc;
        int hits;
        logic [NUM_REQ-1:0] wantV, hitV;
        logic [24:0] hitData;
        hits = 0; hitCyc = -1; hitData = '0; hitV = '0;
        wantV = '0;
        wantV[r] = 1'b1;
        opX[r] = x; opY[r] = '0; opZ[r] = '0;
        accCyc = cyc;
        for (int c = 0; c < RSP_LAT + 3; c++) begin
            stepCycle(1'b1, (c == 0) ? wantV : '0);
            tests++;
            if ({obsReady, obsRspV, obsData, obsIdle} !== {expReady, expRspV, expData, expIdle}) begin
                fails++;
                $display("[TB] FAIL %s cyc=%0d ready=%b want %b rspValid=%b want %b data=%h want %h idle=%b want %b",
                         name, cyc - 1, obsReady, expReady, obsRspV, expRspV, obsData, expData, obsIdle, expIdle);
            end
            if (obsRspV != '0) begin
                hits++; hitCyc = cyc - 1; hitData = obsData; hitV = obsRspV;
            end
        end
        tests++;
        if (hits != 1 || hitCyc != accCyc + RSP_LAT || hitV !== wantV || hitData !== want) begin
            fails++;
            $display("[TB] FAIL %s_latency pulses=%0d at cyc %0d valid=%b data=%h, want 1 pulse at cyc %0d valid=%b data=%h",
                     name, hits, hitCyc, hitV, hitData, accCyc + RSP_LAT, wantV, want);
        end
    endtask

    task automatic test_all_four();
        int nResp;
        logic [NUM_REQ-1:0] want;
        nResp = 0;
        for (int c = 0; c < 2; c++) stepCycle(1'b0, '0);
        for (int i = 0; i < NUM_REQ; i++) newOps(i);
        for (int k = 0; k < 32; k++) begin
            stepCycle(1'b1, (k < 16) ? '1 : '0);
            tests++;
            if ({obsReady, obsRspV, obsData, obsIdle} !== {expReady, expRspV, expData, expIdle}) begin
                fails++;
                $display("[TB] FAIL all_four cyc=%0d ready=%b want %b rspValid=%b want %b data=%h want %h idle=%b want %b",
                         cyc - 1, obsReady, expReady, obsRspV, expRspV, obsData, expData, obsIdle, expIdle);
            end
            if (k < 16) begin
                want = '0;
                want[k % NUM_REQ] = 1'b1;
                tests++;
                if (obsReady !== want) begin
                    fails++;
                    $display("[TB] FAIL all_four_grant k=%0d ready=%b want %b", k, obsReady, want);
                end
                newOps(k % NUM_REQ);
            end
            if (obsRspV != '0) begin
                want = '0;
                want[nResp % NUM_REQ] = 1'b1;
                tests++;
                if (obsRspV !== want) begin
                    fails++;
                    $display("[TB] FAIL all_four_order resp %0d valid=%b want %b", nResp, obsRspV, want);
                end
                nResp++;
            end
        end
        tests++;
        if (nResp != 16) begin
            fails++;
            $display("[TB] FAIL all_four_count got %0d responses want 16", nResp);
        end
    endtask

    task automatic test_stream_req1();
        int n;
        longint first, last;
        n = 0; first = -1; last = -1;
        newOps(1);
        for (int k = 0; k < 8 + RSP_LAT + 2; k++) begin
            stepCycle(1'b1, (k < 8) ? 4'b0010 : 4'b0000);
            tests++;
            if ({obsReady, obsRspV, obsData, obsIdle} !== {expReady, expRspV, expData, expIdle}) begin
                fails++;
                $display("[TB] FAIL stream_req1 cyc=%0d ready=%b want %b rspValid=%b want %b data=%h want %h idle=%b want %b",
                         cyc - 1, obsReady, expReady, obsRspV, expRspV, obsData, expData, obsIdle, expIdle);
            end
            if (k < 8) newOps(1);
            if (obsRspV[1]) begin
                if (first < 0) first = cyc - 1;
                last = cyc - 1;
                n++;
            end
        end
        tests++;
        if (n != 8 || last - first != 7) begin
            fails++;
            $display("[TB] FAIL stream_req1_burst got %0d pulses over %0d cycles want 8 over 8", n, last - first + 1);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        logic [NUM_REQ-1:0] vld;
        stray = 0;
        for (int i = 0; i < NUM_REQ; i++) newOps(i);
        vld = 4'b0111;
        for (int k = 0; k < 3 + 4 + 2 + 3; k++) begin
            if (k < 3) stepCycle(1'b1, vld);
            else if (k < 7) stepCycle(1'b1, '0);
            else if (k < 9) stepCycle(1'b0, '0);
            else stepCycle(1'b1, '0);
            tests++;
            if ({obsReady, obsRspV, obsData, obsIdle} !== {expReady, expRspV, expData, expIdle}) begin
                fails++;
                $display("[TB] FAIL reset_mid cyc=%0d ready=%b want %b rspValid=%b want %b data=%h want %h idle=%b want %b",
                         cyc - 1, obsReady, expReady, obsRspV, expRspV, obsData, expData, obsIdle, expIdle);
            end
            if (k < 3) vld = vld & ~obsReady;
            if (k >= 9 && (obsRspV != '0 || !obsIdle)) stray++;
        end
        tests++;
        if (stray != 0) begin
            fails++;
            $display("[TB] FAIL reset_mid_dropped %0d post-reset cycles busy or responding want 0", stray);
        end
        newOps(3);
        for (int k = 0; k < RSP_LAT + 2; k++) begin
            stepCycle(1'b1, (k == 0) ? 4'b1000 : 4'b0000);
            tests++;
            if ({obsReady, obsRspV, obsData, obsIdle} !== {expReady, expRspV, expData, expIdle}) begin
                fails++;
                $display("[TB] FAIL reset_mid_req3 cyc=%0d ready=%b want %b rspValid=%b want %b data=%h want %h idle=%b want %b",
                         cyc - 1, obsReady, expReady, obsRspV, expRspV, obsData, expData, obsIdle, expIdle);
            end
            if (k == 0 && obsReady !== 4'b1000) begin
                tests++; fails++;
                $display("[TB] FAIL reset_mid_grant ready=%b want 1000", obsReady);
            end
        end
    endtask

    task automatic test_drop_valid();
        logic [NUM_REQ-1:0] pattern [4];
        pattern[0] = 4'b0001; pattern[1] = 4'b0011; pattern[2] = 4'b0000; pattern[3] = 4'b0000;
        stepCycle(1'b0, '0);
        newOps(0); newOps(1);
        for (int k = 0; k < RSP_LAT + 4; k++) begin
            stepCycle(1'b1, (k < 4) ? pattern[k] : '0);
            tests++;
            if ({obsReady, obsRspV, obsData, obsIdle} !== {expReady, expRspV, expData, expIdle}) begin
                fails++;
                $display("[TB] FAIL drop_valid cyc=%0d ready=%b want %b rspValid=%b want %b data=%h want %h idle=%b want %b",
                         cyc - 1, obsReady, expReady, obsRspV, expRspV, obsData, expData, obsIdle, expIdle);
            end
            if (k == 0) newOps(0);
            if (k == 1) begin
                tests++;
                if (obsReady !== 4'b0010) begin
                    fails++;
                    $display("[TB] FAIL drop_valid_priority ready=%b want 0010", obsReady);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] vld;
        logic rstN;
        vld = '0;
        for (int k = 0; k < 300 + RSP_LAT + 2; k++) begin
            rstN = ($urandom_range(0, 99) != 0);
            if (k >= 300) vld = '0;
            stepCycle(rstN, vld);
            tests++;
            if ({obsReady, obsRspV, obsData, obsIdle} !== {expReady, expRspV, expData, expIdle}) begin
                fails++;
                $display("[TB] FAIL random cyc=%0d ready=%b want %b rspValid=%b want %b data=%h want %h idle=%b want %b",
                         cyc - 1, obsReady, expReady, obsRspV, expRspV, obsData, expData, obsIdle, expIdle);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (expReady[i]) begin
                    newOps(i);
                    vld[i] = $urandom_range(0, 1) == 1;
                end else if (vld[i]) begin
                    if ($urandom_range(0, 9) == 0) vld[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    newOps(i);
                    vld[i] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        srst_n    = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_z     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            opX[i] = '0; opY[i] = '0; opZ[i] = '0;
        end
        repeat (2) @(posedge clk);
        test_reset();
        test_single("single_req0", 0, ONE_Q4_20, 25'h1000000);
        test_single("single_req2", 2, 24'h200000, 25'h0800000);
        test_all_four();
        test_stream_req1();
        test_reset_mid();
        test_drop_valid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inv_sqrt_arbiter.md
# inv_sqrt_arbiter

Shares the single pipelined `inv_sqrt` unit (inputs 4Q20 x/y/z, output 1Q24 1/|v|, 12-cycle pipeline) between several requesters. Requesters include vertex shader camera-basis normalization (CamZ/CamX/CamY) and lighting normal normalization. Round-robin grants at most one request per cycle. The block tracks in-flight ownership with a tag shift register and routes each fixed-latency result back to its issuer. Responses are not back-pressured.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `LAT`, default 12: pipeline depth of `inv_sqrt` in clock edges.
- `clk`  in  1  clock.
- `srst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NUM_REQ  request strobe per requester.
- `req_ready`  out  NUM_REQ  grant; one-hot or zero; combinational from `req_valid` and the RR pointer.
- `req_x`, `req_y`, `req_z`  in  NUM_REQ*24 each  flattened 4Q20 signed operands; slice i = [24i+23:24i].
- `rsp_valid`  out  NUM_REQ  one-cycle result strobe to the owning requester.
- `rsp_data`  out  25  1Q24 result; meaningful only where `rsp_valid` is set; held when idle.
- `idle`  out  1  high when no request is in flight.

## Operation
- Handshake: requester i is accepted in cycle c when `req_valid[i] & req_ready[i]` is high during c. The requester must hold valid and operands stable until accepted.
- Arbitration: round-robin over `req_valid`.
  - Search starts at `rr_ptr`; first asserted index wins.
  - On accept of i, `rr_ptr <= (i+1) mod NUM_REQ`.
  - With no request, `rr_ptr` holds.
  - A single active requester is granted every cycle (full throughput).
- Issue: on accept, operands of the winner are registered into the `inv_sqrt` input registers `op_x/op_y/op_z`. The `{valid, tag}` pair enters stage 0 of a tag pipe of depth LAT+1. Tag width is clog2(NUM_REQ).
- Without an accept, the tag pipe shifts in valid=0 and operand registers hold.
- Return: when the tag pipe output is valid with tag t:
  - `rsp_valid[t]=1` and all other bits are 0.
  - `rsp_data` is the `inv_sqrt` output, registered.
- Ordering: responses are per-requester in order, since latency is fixed. Any number of requests from one requester may be in flight, up to LAT+1 total.
- `idle` is the NOR of all tag-pipe valid bits and the accept of the current cycle.
- No state machine beyond the RR pointer and the tag pipe. The block runs a fixed pipeline schedule.
- Width: the block passes data unchanged. Zero-vector handling belongs to `inv_sqrt`, and the arbiter forwards whatever it produces.

## Timing
- Latency: accept in cycle c gives `rsp_valid` high exactly during cycle c+LAT+2. This is 1 operand-register edge, LAT pipeline edges, and 1 output-register edge.
- Throughput: 1 accept per cycle aggregate.
- Reset values:
  - `req_ready=0` during reset.
  - `rsp_valid=0`, `rsp_data=0`, `idle=1`, `rr_ptr=0`.
  - All tag-pipe valid bits are 0.
- Reset mid-operation: all in-flight requests are dropped. No `rsp_valid` appears for them after reset deasserts, even though `inv_sqrt` internal data is not cleared.
- Simultaneous requests: only the winner sees ready. Losers keep valid and are served in RR order. Worst-case wait is NUM_REQ-1 cycles.
- A requester deasserting valid before acceptance is legal; it simply loses its slot.
- A response and a new accept for the same requester in the same cycle are independent and both are legal.

## Structure
- Shared package `vs_pkg`:
  - Fixed-point constants `Q4_20_W=24`, `Q1_24_W=25`, `INV_SQRT_LAT=12`.
  - Constant `ONE_Q4_20=24'h100000`.
- Sub-modules:
  - The existing `inv_sqrt` is instantiated unchanged.
  - One natural sub-module is `rr_arbiter`: a parameterized round-robin grant with pointer update.
- The tag pipe stays inline.

## Test plan
- Single requester 0, operands (0x100000, 0, 0) accepted in cycle 5 -> `rsp_valid=4'b0001` only in cycle 19, `rsp_data=25'h1000000`.
- Requester 2, operands (0x200000, 0, 0) -> `rsp_data=25'h0800000` (0.5), only `rsp_valid[2]` set, exactly LAT+2 cycles after accept.
- All four requesters valid continuously from cycle 0 with `rr_ptr=0` -> grants 0,1,2,3,0,… one per cycle; responses return in the same order, back-to-back, with none lost.
- Requester 1 streams 8 consecutive requests with distinct vectors -> 8 consecutive `rsp_valid[1]` pulses, in order, data matching the `inv_sqrt` model.
- Reset asserted 4 cycles after 3 accepts, released 2 cycles later -> no `rsp_valid` for the dropped requests; `idle=1`; the next accept from requester 3 is granted first (`rr_ptr=0`, only requester 3 valid) with normal latency.
- Requester 0 raises then drops valid while requester 1 holds priority -> no grant to 0, no response for 0; requester 1 is served normally.
